// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte producers.
// Each producer owns a small FIFO; the FSM pops one byte at a time and sequences uart_tx.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_start_o,
    input  logic                   tx_busy_i,
    output logic [NUM_REQ-1:0]     grant_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO
    } state_t;

    logic [7:0]         mem_q    [NUM_REQ][FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q [NUM_REQ];
    logic [AW:0]        wr_ptr_d [NUM_REQ];
    logic [AW:0]        rd_ptr_q [NUM_REQ];
    logic [AW:0]        rd_ptr_d [NUM_REQ];
    logic [NUM_REQ-1:0] empty;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic               found;
    logic [PW-1:0]      winner;
    int                 idx;

    // Extra pointer bit tells a full FIFO apart from an empty one.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                       (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
        end
    end

    assign req_ready_o = ~full;
    assign push        = req_valid_i & ~full;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(pop[i]);
        end
    end

    // Search starts just after the last winner so every port gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && !empty[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        grant_d    = grant_q;
        pop        = '0;
        case (state_q)
            IDLE: begin
                if (found && !tx_busy_i) begin
                    pop[winner]     = 1'b1;
                    tx_data_d       = mem_q[winner][rd_ptr_q[winner][AW-1:0]];
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    rr_ptr_d        = winner;
                    tx_start_d      = 1'b1;
                    state_d         = START;
                end
            end
            START:   state_d = WAIT_HI;
            WAIT_HI: if (tx_busy_i) state_d = WAIT_LO;
            WAIT_LO: begin
                if (!tx_busy_i) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: payload storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= req_data_i[8*i +: 8];
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PW'(NUM_REQ - 1);
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            grant_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            grant_q    <= grant_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign grant_o    = grant_q;

endmodule
